trig_unit: RTL and testbench

TRIG_UNIT -- requirements
Module: trig_unit

---
 rtl/trig_if.sv | 22 ++
 rtl/trig_unit.sv | 243 ++++++++++++++++++++++++
 tb/tb_trig_unit.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/trig_if.sv
// Execute-stage handshake between the pipeline and the CORDIC sine/cosine unit.
// The pipeline (master) issues requests and the trig unit (slave) answers with stall/done/result.
interface trig_if;
    logic        start;
    logic        cos_sel;
    logic [31:0] angle;
    logic        flush;
    logic        stall;
    logic        busy;
    logic        done;
    logic [31:0] result;

    modport master (
        output start, cos_sel, angle, flush,
        input  stall, busy, done, result
    );

    modport slave (
        input  start, cos_sel, angle, flush,
        output stall, busy, done, result
    );
endinterface

// File: rtl/trig_unit.sv
// Iterative 14-step CORDIC producing sin/cos of a Q3.13 angle as a Q2.14 result.
// Holds the pipeline via a combinational stall while the iteration runs.
module trig_unit (
    input  logic   clk,
    input  logic   rst,
    trig_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INIT = 2'd1,
        ITER = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic signed [17:0] K_INIT    = 18'sd9949;
    localparam logic signed [17:0] PI_Q13    = 18'sd25736;
    localparam logic signed [17:0] HPI_Q13   = 18'sd12868;
    localparam logic signed [15:0] ANG_MAX   = 16'sd25736;
    localparam logic signed [15:0] ANG_MIN   = -16'sd25736;
    localparam logic signed [18:0] RES_MAX   = 19'sd16384;
    localparam logic signed [18:0] RES_MIN   = -19'sd16384;
    localparam logic [3:0]         LAST_ITER = 4'd13;

    // round(atan(2^-i) * 8192)
    function automatic logic signed [17:0] atan_lut(input logic [3:0] idx);
        logic signed [17:0] val;
        case (idx)
            4'd0:    val = 18'sd6434;
            4'd1:    val = 18'sd3798;
            4'd2:    val = 18'sd2007;
            4'd3:    val = 18'sd1019;
            4'd4:    val = 18'sd511;
            4'd5:    val = 18'sd256;
            4'd6:    val = 18'sd128;
            4'd7:    val = 18'sd64;
            4'd8:    val = 18'sd32;
            4'd9:    val = 18'sd16;
            4'd10:   val = 18'sd8;
            4'd11:   val = 18'sd4;
            4'd12:   val = 18'sd2;
            4'd13:   val = 18'sd1;
            default: val = 18'sd0;
        endcase
        return val;
    endfunction

    function automatic logic signed [15:0] sat_angle(input logic signed [15:0] a);
        logic signed [15:0] val;
        if (a > ANG_MAX) begin
            val = ANG_MAX;
        end else if (a < ANG_MIN) begin
            val = ANG_MIN;
        end else begin
            val = a;
        end
        return val;
    endfunction

    // Undo the quadrant fold, clamp to +/-1.0 and sign-extend to the bus width
    function automatic logic [31:0] shape_result(input logic signed [17:0] v, input logic neg);
        logic signed [18:0] wide;
        logic signed [18:0] clamped;
        wide = {v[17], v};
        if (neg) begin
            wide = -wide;
        end else begin
            wide = wide;
        end
        if (wide > RES_MAX) begin
            clamped = RES_MAX;
        end else if (wide < RES_MIN) begin
            clamped = RES_MIN;
        end else begin
            clamped = wide;
        end
        return {{13{clamped[18]}}, clamped};
    endfunction

    state_t             state_r;
    state_t             state_s;
    logic               accept_s;
    logic               stall_s;
    logic               cos_r;
    logic signed [15:0] ang_r;
    logic               neg_r;
    logic [3:0]         iter_r;
    logic signed [17:0] x_r;
    logic signed [17:0] y_r;
    logic signed [17:0] z_r;
    logic signed [17:0] z_fold_s;
    logic               neg_fold_s;
    logic signed [17:0] x_n_s;
    logic signed [17:0] y_n_s;
    logic signed [17:0] z_n_s;
    logic               busy_r;
    logic               done_r;
    logic [31:0]        result_r;

    assign accept_s = bus.start && !bus.flush && ((state_r == IDLE) || (state_r == DONE));

    // Next-state selection; flush wins over everything but reset
    always_comb begin
        state_s = state_r;
        if (bus.flush) begin
            state_s = IDLE;
        end else begin
            case (state_r)
                IDLE:    state_s = bus.start ? INIT : IDLE;
                INIT:    state_s = ITER;
                ITER:    state_s = (iter_r == LAST_ITER) ? DONE : ITER;
                DONE:    state_s = bus.start ? INIT : IDLE;
                default: state_s = IDLE;
            endcase
        end
    end

    // Pipeline stall: raised as soon as a request is seen, dropped on flush or reset
    always_comb begin
        stall_s = 1'b0;
        if (!rst) begin
            stall_s = 1'b0;
        end else if (bus.flush) begin
            stall_s = 1'b0;
        end else begin
            case (state_r)
                IDLE:    stall_s = bus.start;
                INIT:    stall_s = 1'b1;
                ITER:    stall_s = 1'b1;
                DONE:    stall_s = bus.start;
                default: stall_s = 1'b0;
            endcase
        end
    end

    // Fold the captured angle into [-pi/2, pi/2] and remember whether to negate
    always_comb begin
        z_fold_s   = {{2{ang_r[15]}}, ang_r};
        neg_fold_s = 1'b0;
        if (z_fold_s > HPI_Q13) begin
            z_fold_s   = z_fold_s - PI_Q13;
            neg_fold_s = 1'b1;
        end else if (z_fold_s < -HPI_Q13) begin
            z_fold_s   = z_fold_s + PI_Q13;
            neg_fold_s = 1'b1;
        end else begin
            neg_fold_s = 1'b0;
        end
    end

    // One CORDIC rotation step driven by the sign of the residual angle
    always_comb begin
        x_n_s = x_r;
        y_n_s = y_r;
        z_n_s = z_r;
        if (z_r >= 18'sd0) begin
            x_n_s = x_r - (y_r >>> iter_r);
            y_n_s = y_r + (x_r >>> iter_r);
            z_n_s = z_r - atan_lut(iter_r);
        end else begin
            x_n_s = x_r + (y_r >>> iter_r);
            y_n_s = y_r - (x_r >>> iter_r);
            z_n_s = z_r + atan_lut(iter_r);
        end
    end

    // State register and registered status outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s == INIT) || (state_s == ITER);
            done_r  <= (state_s == DONE);
        end
    end

    // Operand capture on request acceptance; saturation is applied here once
    always_ff @(posedge clk) begin
        if (!rst) begin
            cos_r <= 1'b0;
            ang_r <= 16'sd0;
        end else if (accept_s) begin
            cos_r <= bus.cos_sel;
            ang_r <= sat_angle(bus.angle[15:0]);
        end else begin
            cos_r <= cos_r;
            ang_r <= ang_r;
        end
    end

    // CORDIC datapath: load in INIT, rotate in ITER, hold otherwise
    always_ff @(posedge clk) begin
        if (!rst) begin
            x_r    <= 18'sd0;
            y_r    <= 18'sd0;
            z_r    <= 18'sd0;
            neg_r  <= 1'b0;
            iter_r <= 4'd0;
        end else begin
            case (state_r)
                INIT: begin
                    x_r    <= K_INIT;
                    y_r    <= 18'sd0;
                    z_r    <= z_fold_s;
                    neg_r  <= neg_fold_s;
                    iter_r <= 4'd0;
                end
                ITER: begin
                    x_r    <= x_n_s;
                    y_r    <= y_n_s;
                    z_r    <= z_n_s;
                    iter_r <= iter_r + 4'd1;
                end
                default: begin
                    x_r    <= x_r;
                    y_r    <= y_r;
                    z_r    <= z_r;
                    iter_r <= iter_r;
                end
            endcase
        end
    end

    // Result is taken from the final rotation so it is valid in the DONE cycle
    always_ff @(posedge clk) begin
        if (!rst) begin
            result_r <= 32'd0;
        end else if ((state_r == ITER) && (iter_r == LAST_ITER) && !bus.flush) begin
            result_r <= shape_result(cos_r ? x_n_s : y_n_s, neg_r);
        end else begin
            result_r <= result_r;
        end
    end

    assign bus.stall  = stall_s;
    assign bus.busy   = busy_r;
    assign bus.done   = done_r;
    assign bus.result = result_r;

endmodule

// File: tb/tb_trig_unit.sv
// Randomized and directed bench for trig_unit against a behavioural CORDIC model
// plus the absolute accuracy targets for the directed angles.
module tb_trig_unit;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    int   model_res;

    trig_if bus ();

    trig_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input longint obs, input longint exp, input longint tol = 0);
        longint diff;
        checks++;
        diff = (obs > exp) ? (obs - exp) : (exp - obs);
        if (diff > tol) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (tol %0d)", tag, obs, exp, tol);
        end
    endtask

    // Spec-level model: saturate, fold, run 14 rotations with integer arithmetic, unfold, clamp
    function automatic int ref_trig(input bit cs, input logic [31:0] ang);
        int tab [14] = '{6434, 3798, 2007, 1019, 511, 256, 128, 64, 32, 16, 8, 4, 2, 1};
        int a, x, y, z, nx, ny, v;
        bit neg;
        logic signed [15:0] lo;
        lo = ang[15:0];
        a = int'(lo);
        if (a > 25736) a = 25736;
        if (a < -25736) a = -25736;
        neg = 1'b0;
        if (a > 12868) begin a = a - 25736; neg = 1'b1; end
        else if (a < -12868) begin a = a + 25736; neg = 1'b1; end
        x = 9949; y = 0; z = a;
        for (int i = 0; i < 14; i++) begin
            if (z >= 0) begin
                nx = x - (y >>> i); ny = y + (x >>> i); z = z - tab[i];
            end else begin
                nx = x + (y >>> i); ny = y - (x >>> i); z = z + tab[i];
            end
            x = nx; y = ny;
        end
        v = cs ? x : y;
        if (neg) v = -v;
        if (v > 16384) v = 16384;
        if (v < -16384) v = -16384;
        return v;
    endfunction

    function automatic logic [31:0] mk_angle(input logic [15:0] upper, input int a);
        logic [31:0] t;
        t = a;
        return {upper, t[15:0]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue a request in cycle T and leave the bench in cycle T+1 with operands scrambled
    task automatic launch(input bit cs, input logic [31:0] ang);
        bus.start   = 1'b1;
        bus.cos_sel = cs;
        bus.angle   = ang;
        bus.flush   = 1'b0;
        #1;
        chk("stall_on_start", bus.stall, 1);
        step();
        bus.start   = 1'b0;
        bus.cos_sel = ~cs;
        bus.angle   = $urandom;
    endtask

    // Walk cycles T+from .. T+to-1 checking that the unit is busy and stalling
    task automatic run_to(input int from_c, input int to_c, input bit poke5);
        for (int c = from_c; c < to_c; c++) begin
            if (poke5 && c == 5) begin
                bus.start   = 1'b1;
                bus.cos_sel = $urandom_range(1, 0);
                bus.angle   = $urandom;
            end
            #1;
            chk("stall_busy_phase", bus.stall, 1);
            chk("busy_phase", bus.busy, 1);
            chk("no_early_done", bus.done, 0);
            step();
            bus.start = 1'b0;
        end
    endtask

    task automatic expect_done(input int exp);
        chk("done_at_T16", bus.done, 1);
        chk("busy_in_done", bus.busy, 0);
        chk("stall_low_done", bus.stall, 0);
        chk("result", longint'($signed(bus.result)), exp);
        model_res = exp;
    endtask

    task automatic full_op(input bit cs, input logic [31:0] ang, input bit poke5,
                           input bit acc, input int acc_exp);
        int exp;
        exp = ref_trig(cs, ang);
        launch(cs, ang);
        run_to(1, 16, poke5);
        expect_done(exp);
        if (acc) chk("accuracy", longint'($signed(bus.result)), acc_exp, 4);
        step();
        chk("done_single_pulse", bus.done, 0);
        chk("result_hold", longint'($signed(bus.result)), model_res);
    endtask

    int dir_ang [7];
    bit dir_cs  [7];
    int dir_exp [7];

    initial begin
        checks    = 0;
        failures  = 0;
        model_res = 0;
        rst         = 1'b0;
        bus.start   = 1'b1;
        bus.cos_sel = 1'b0;
        bus.angle   = 32'd0;
        bus.flush   = 1'b0;

        // Reset state, with start held high to confirm it is ignored
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_stall", bus.stall, 0);
            chk("rst_result", longint'(bus.result), 0);
            chk("rst_done", bus.done, 0);
            chk("rst_busy", bus.busy, 0);
        end
        rst       = 1'b1;
        bus.start = 1'b0;
        step();
        chk("idle_busy", bus.busy, 0);
        chk("idle_stall", bus.stall, 0);

        // Directed angles with absolute targets
        dir_cs  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        dir_ang = '{0, 0, 12868, 25736, -6434, 32767, 0};
        dir_exp = '{0, 16384, 16384, -16384, -11585, 0, 0};
        for (int i = 0; i < 7; i++) begin
            full_op(dir_cs[i], mk_angle((i == 6) ? 16'hFFFF : 16'h0000, dir_ang[i]), 1'b0, 1'b1, dir_exp[i]);
        end

        // Start pulse mid-operation must be ignored
        full_op(1'b0, mk_angle(16'h0, 5000), 1'b1, 1'b0, 0);
        full_op(1'b1, mk_angle(16'h0, -20000), 1'b1, 1'b0, 0);

        // Back-to-back: restart from the DONE cycle
        begin
            int e1, e2;
            e1 = ref_trig(1'b0, mk_angle(16'h0, 3000));
            e2 = ref_trig(1'b1, mk_angle(16'h0, -9000));
            launch(1'b0, mk_angle(16'h0, 3000));
            run_to(1, 16, 1'b0);
            expect_done(e1);
            launch(1'b1, mk_angle(16'h0, -9000));
            run_to(1, 16, 1'b0);
            expect_done(e2);
            step();
            chk("b2b_done_pulse", bus.done, 0);
        end

        // Flush at T+7
        launch(1'b1, mk_angle(16'h0, 7000));
        run_to(1, 7, 1'b0);
        bus.flush = 1'b1;
        #1;
        chk("flush_stall_low", bus.stall, 0);
        step();
        bus.flush = 1'b0;
        chk("flush_idle", bus.busy, 0);
        for (int i = 0; i < 20; i++) begin
            chk("flush_no_done", bus.done, 0);
            chk("flush_result_hold", longint'($signed(bus.result)), model_res);
            step();
        end
        bus.start = 1'b1;
        bus.flush = 1'b1;
        #1;
        chk("flush_over_start_stall", bus.stall, 0);
        step();
        bus.start = 1'b0;
        bus.flush = 1'b0;
        chk("flush_over_start_idle", bus.busy, 0);
        for (int i = 0; i < 18; i++) begin
            chk("flush_over_start_no_done", bus.done, 0);
            step();
        end

        // Reset at T+9 aborts silently
        launch(1'b0, mk_angle(16'h0, 10000));
        run_to(1, 9, 1'b0);
        rst       = 1'b0;
        bus.start = 1'b1;
        #1;
        chk("midrst_stall", bus.stall, 0);
        step();
        rst       = 1'b1;
        bus.start = 1'b0;
        model_res = 0;
        chk("midrst_result", longint'(bus.result), 0);
        chk("midrst_done", bus.done, 0);
        chk("midrst_busy", bus.busy, 0);
        for (int i = 0; i < 20; i++) begin
            chk("midrst_no_done", bus.done, 0);
            step();
        end
        full_op(1'b0, mk_angle(16'h0, 6434), 1'b0, 1'b1, 11585);

        // Randomized operations across the full 32-bit operand space
        for (int n = 0; n < 40; n++) begin
            logic [31:0] ra;
            bit rc;
            ra = $urandom;
            rc = $urandom_range(1, 0);
            full_op(rc, ra, ($urandom_range(3, 0) == 0), 1'b0, 0);
            for (int g = 0; g < $urandom_range(2, 0); g++) step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
